// File: rtl/dcache_resp_mem.sv
// Data-side responder for the execute-stage dcache bus: byte-strobed word SRAM
// with configurable read latency and post-write busy time.
module dcache_resp_mem #(
  parameter int ADDR_WIDTH = 10,
  parameter int RD_LATENCY = 2,
  parameter int WR_BUSY    = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [105:0] dcache_wdata_bus,
  output logic [33:0]  dcache_rdata_bus
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RBUSY = 2'd1;
  localparam logic [1:0] RRESP = 2'd2;
  localparam logic [1:0] WBUSY = 2'd3;
  localparam int DEPTH = 1 << ADDR_WIDTH;

  generate
    if (ADDR_WIDTH < 1 || ADDR_WIDTH > 30 || RD_LATENCY < 1 || RD_LATENCY > 15 ||
        WR_BUSY < 0 || WR_BUSY > 15) begin : g_bad_cfg
      $error("dcache_resp_mem: parameter out of range");
    end
  endgenerate

  logic                  req_valid;
  logic                  req_op;
  logic [31:0]           req_addr;
  logic [3:0]            req_strb;
  logic [31:0]           req_wdata;
  logic                  req_cacop;
  logic [ADDR_WIDTH-1:0] idx;

  assign req_valid = dcache_wdata_bus[105];
  assign req_op    = dcache_wdata_bus[104];
  assign req_addr  = dcache_wdata_bus[103:72];
  assign req_strb  = dcache_wdata_bus[70:67];
  assign req_wdata = dcache_wdata_bus[66:35];
  assign req_cacop = dcache_wdata_bus[34];
  assign idx       = req_addr[ADDR_WIDTH+1:2];

  // uncached, cacop code/address and the address bits outside the index are don't-cares
  logic unused_bits;
  assign unused_bits = ^{dcache_wdata_bus[71], dcache_wdata_bus[33:0], req_addr};

  logic [1:0]  state;
  logic [3:0]  cnt;
  logic [31:0] rdata_q;
  logic [31:0] mem [DEPTH];
  logic        ready;
  logic        rvalid;
  logic        accept;
  logic        wr_fire;

  assign ready   = reset && (state == IDLE);
  assign rvalid  = reset && (state == RRESP);
  assign accept  = req_valid && ready;
  assign wr_fire = accept && req_op && !req_cacop;

  always_ff @(posedge clk) begin
    if (wr_fire) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (req_strb[i]) mem[idx][8*i +: 8] <= req_wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= IDLE;
      cnt     <= '0;
      rdata_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            if (req_cacop || req_op) begin
              if (WR_BUSY == 0) begin
                state <= IDLE;
              end else begin
                state <= WBUSY;
                cnt   <= 4'(WR_BUSY);
              end
            end else begin
              rdata_q <= mem[idx];
              if (RD_LATENCY == 1) begin
                state <= RRESP;
              end else begin
                state <= RBUSY;
                cnt   <= 4'(RD_LATENCY - 1);
              end
            end
          end
        end
        RBUSY: begin
          if (cnt == 4'd1) state <= RRESP;
          else             cnt   <= cnt - 4'd1;
        end
        RRESP: state <= IDLE;
        WBUSY: begin
          if (cnt == 4'd1) state <= IDLE;
          else             cnt   <= cnt - 4'd1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign dcache_rdata_bus = {ready, rvalid, rvalid ? rdata_q : 32'h0};

endmodule

// File: tb/tb_dcache_resp_mem.sv
// Directed bench for dcache_resp_mem: four differently-parameterised instances
// checked every cycle against a cycle-number timing model, plus literal checks.
`timescale 1ns/1ps
module tb_dcache_resp_mem;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset;
  logic [105:0] bus  [4];
  logic [33:0]  rbus [4];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  bit chk_en = 1'b0;

  int          lat_of [4] = '{2, 1, 15, 4};
  int          wb_of  [4] = '{1, 3, 0, 1};
  int          free_at [4];
  int          rv_at   [4];
  logic [31:0] rv_data [4];
  int          rv_seen [4] = '{0, 0, 0, 0};
  logic [31:0] mdl_mem [int];

  dcache_resp_mem #(.ADDR_WIDTH(10), .RD_LATENCY(2), .WR_BUSY(1)) u_dut0 (
    .clk(clk), .reset(reset), .dcache_wdata_bus(bus[0]), .dcache_rdata_bus(rbus[0]));
  dcache_resp_mem #(.ADDR_WIDTH(10), .RD_LATENCY(1), .WR_BUSY(3)) u_dut1 (
    .clk(clk), .reset(reset), .dcache_wdata_bus(bus[1]), .dcache_rdata_bus(rbus[1]));
  dcache_resp_mem #(.ADDR_WIDTH(10), .RD_LATENCY(15), .WR_BUSY(0)) u_dut2 (
    .clk(clk), .reset(reset), .dcache_wdata_bus(bus[2]), .dcache_rdata_bus(rbus[2]));
  dcache_resp_mem #(.ADDR_WIDTH(10), .RD_LATENCY(4), .WR_BUSY(1)) u_dut3 (
    .clk(clk), .reset(reset), .dcache_wdata_bus(bus[3]), .dcache_rdata_bus(rbus[3]));

  // Model: cyc is the number of the edge just taken; "cycle n" is the period after edge n.
  // A read accepted at edge e is answered in cycle e+L-1 and ready returns in cycle e+L;
  // a write/cacop keeps ready low through cycle e+W-1.
  logic [31:0] m_addr;
  logic [31:0] m_word;
  int          m_key;
  always @(posedge clk) begin
    cyc = cyc + 1;
    if (reset !== 1'b1) chk_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (reset !== 1'b1) begin
        free_at[i] = cyc;
        rv_at[i]   = -100;
      end else if (bus[i][105] === 1'b1 && (cyc - 1) >= free_at[i]) begin
        m_addr = bus[i][103:72];
        m_key  = i * 65536 + int'((m_addr >> 2) % 32'd1024);
        if (bus[i][34] === 1'b1) begin
          free_at[i] = cyc + wb_of[i];
        end else if (bus[i][104] === 1'b1) begin
          m_word = mdl_mem.exists(m_key) ? mdl_mem[m_key] : 32'hxxxxxxxx;
          for (int b = 0; b < 4; b++)
            if (bus[i][67+b]) m_word[8*b +: 8] = bus[i][35+8*b +: 8];
          mdl_mem[m_key] = m_word;
          free_at[i] = cyc + wb_of[i];
        end else begin
          rv_data[i] = mdl_mem.exists(m_key) ? mdl_mem[m_key] : 32'hxxxxxxxx;
          rv_at[i]   = cyc + lat_of[i] - 1;
          free_at[i] = cyc + lat_of[i];
        end
      end
    end
  end

  logic        exp_rdy;
  logic        exp_rv;
  logic [33:0] exp_bus;
  always @(posedge clk) begin
    #1;
    if (chk_en) begin
      for (int i = 0; i < 4; i++) begin
        exp_rdy = (reset === 1'b1) && (cyc >= free_at[i]);
        exp_rv  = (reset === 1'b1) && (cyc == rv_at[i]);
        exp_bus = {exp_rdy, exp_rv, exp_rv ? rv_data[i] : 32'h0};
        checks++;
        if (rbus[i] !== exp_bus) begin
          errors++;
          $display("FAIL model_bus%0d cycle %0d: got %h expected %h", i, cyc, rbus[i], exp_bus);
        end
        if (rbus[i][32] === 1'b1) rv_seen[i]++;
      end
    end
  end

  task automatic chk(input string name, input logic [33:0] got, input logic [33:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic drive(input int i, input bit op, input logic [31:0] addr,
                       input logic [3:0] strb, input logic [31:0] wd, input bit cop);
    bus[i] = {1'b1, op, addr, 1'b0, strb, wd, cop, 2'b00, 32'h0};
  endtask

  task automatic wait_acc(input int i, output int e);
    int k = 0;
    while (rbus[i][33] !== 1'b1 && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (k >= 100) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout bus%0d: got no ready expected ready within 100 cycles", i);
    end
    @(negedge clk);
    e = cyc;
  endtask

  task automatic do_req(input int i, input bit op, input logic [31:0] addr,
                        input logic [3:0] strb, input logic [31:0] wd, input bit cop,
                        output int e);
    @(negedge clk);
    drive(i, op, addr, strb, wd, cop);
    wait_acc(i, e);
    bus[i][105] = 1'b0;
  endtask

  task automatic do_read(input int i, input logic [31:0] addr,
                         output logic [31:0] data, output int lat);
    int e;
    int k = 0;
    do_req(i, 1'b0, addr, 4'h0, 32'h0, 1'b0, e);
    while (rbus[i][32] !== 1'b1 && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (k >= 100) begin
      checks++;
      errors++;
      $display("FAIL rvalid_timeout bus%0d: got no rvalid expected rvalid within 100 cycles", i);
    end
    data = rbus[i][31:0];
    lat  = cyc - e + 1;
  endtask

  logic [31:0] rd;
  int          lat;
  int          e1, e2, snap;

  initial begin
    reset = 1'b0;
    for (int i = 0; i < 4; i++) bus[i] = '0;
    repeat (3) @(negedge clk);
    chk("reset_bus1", rbus[1], 34'h0);
    reset = 1'b1;
    @(negedge clk);
    chk("ready_after_reset", rbus[0], {1'b1, 1'b0, 32'h0});

    // single write then read, RD_LATENCY=2
    do_req(0, 1'b1, 32'h0000_0010, 4'hF, 32'hDEADBEEF, 1'b0, e1);
    do_read(0, 32'h0000_0010, rd, lat);
    chk("rw_data", {2'b0, rd}, {2'b0, 32'hDEADBEEF});
    chk("rw_latency", 34'(lat), 34'd2);
    chk("rw_not_ready_in_rresp", {33'h0, rbus[0][33]}, 34'h0);
    @(negedge clk);
    chk("rw_ready_after_rresp", {33'h0, rbus[0][33]}, 34'h1);

    // byte strobes and ignored addr[1:0]
    do_req(0, 1'b1, 32'h0000_0020, 4'hF, 32'h11223344, 1'b0, e1);
    do_req(0, 1'b1, 32'h0000_0020, 4'b0010, 32'h0000AA00, 1'b0, e1);
    do_req(0, 1'b1, 32'h0000_0020, 4'b0000, 32'hFFFFFFFF, 1'b0, e1);
    do_read(0, 32'h0000_0022, rd, lat);
    chk("strobe_merge", {2'b0, rd}, {2'b0, 32'h1122AA44});

    // back-to-back writes with valid held, WR_BUSY=3
    @(negedge clk);
    drive(1, 1'b1, 32'h0000_0040, 4'hF, 32'hA5A5A5A5, 1'b0);
    wait_acc(1, e1);
    drive(1, 1'b1, 32'h0000_0044, 4'hF, 32'h5A5A5A5A, 1'b0);
    wait_acc(1, e2);
    bus[1][105] = 1'b0;
    chk("wbusy3_spacing", 34'(e2 - e1), 34'd4);
    do_read(1, 32'h0000_0040, rd, lat);
    chk("wbusy3_first", {2'b0, rd}, {2'b0, 32'hA5A5A5A5});
    chk("lat1", 34'(lat), 34'd1);
    do_read(1, 32'h0000_0044, rd, lat);
    chk("wbusy3_second", {2'b0, rd}, {2'b0, 32'h5A5A5A5A});

    // WR_BUSY=0 writes every cycle, RD_LATENCY=15
    @(negedge clk);
    drive(2, 1'b1, 32'h0000_0100, 4'hF, 32'h01020304, 1'b0);
    wait_acc(2, e1);
    drive(2, 1'b1, 32'h0000_0104, 4'hF, 32'h05060708, 1'b0);
    wait_acc(2, e2);
    bus[2][105] = 1'b0;
    chk("wbusy0_spacing", 34'(e2 - e1), 34'd1);
    do_read(2, 32'h0000_0104, rd, lat);
    chk("lat15_data", {2'b0, rd}, {2'b0, 32'h05060708});
    chk("lat15", 34'(lat), 34'd15);

    // aliasing and cacop
    do_req(0, 1'b1, 32'h0000_1004, 4'hF, 32'hCAFEF00D, 1'b0, e1);
    do_read(0, 32'h0000_0004, rd, lat);
    chk("alias", {2'b0, rd}, {2'b0, 32'hCAFEF00D});
    do_req(0, 1'b1, 32'h0000_0004, 4'hF, 32'h00000000, 1'b1, e1);
    do_read(0, 32'h0000_1004, rd, lat);
    chk("cacop_no_write", {2'b0, rd}, {2'b0, 32'hCAFEF00D});

    // reset while a read is in flight, RD_LATENCY=4
    do_req(3, 1'b1, 32'h0000_0080, 4'hF, 32'h0BADC0DE, 1'b0, e1);
    snap = rv_seen[3];
    do_req(3, 1'b0, 32'h0000_0080, 4'h0, 32'h0, 1'b0, e1);
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("ready_after_release", {33'h0, rbus[3][33]}, 34'h1);
    repeat (20) @(negedge clk);
    chk("dropped_read_no_rvalid", 34'(rv_seen[3] - snap), 34'd0);
    do_read(3, 32'h0000_0080, rd, lat);
    chk("post_reset_read", {2'b0, rd}, {2'b0, 32'h0BADC0DE});
    chk("lat4", 34'(lat), 34'd4);
    do_read(0, 32'h0000_0010, rd, lat);
    chk("mem_kept_over_reset", {2'b0, rd}, {2'b0, 32'hDEADBEEF});

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion expected finish before 200000ns");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/dcache_resp_mem.md
Name: dcache_resp_mem

Overview:
- Responder end of the execute-stage data-cache bus: consumes the packed request bus that the load/store unit drives and returns the packed {ready, rvalid, rdata} bus.
- Backed by a word-addressed, byte-strobed SRAM model with configurable read and write latency.
- Used as the data-side memory in simulation and in bring-up builds before the real dcache lands.
- Enforces the handshake timing the load/store unit depends on: acceptance on valid&&ready, and read data always one or more cycles after acceptance.

Parameters:
ADDR_WIDTH, 10, word-index bits; capacity 4*2^ADDR_WIDTH bytes (4 KiB default).
RD_LATENCY, 2, cycles from the read-accept edge to the rvalid cycle; legal range 1..15.
WR_BUSY, 1, cycles ready stays low after a write or cacop accept; legal range 0..15.

Ports:
clk  in  1  clock; all state changes on the rising edge.
reset  in  1  synchronous, active-low reset; reset==0 at a rising edge resets the block.
dcache_wdata_bus  in  `EXM_DCACHE_WD (106)  request bus, MSB first: valid[105], op[104] (0=read, 1=write), addr[103:72], uncached[71], awstrb[70:67], wdata[66:35], cacop_en[34], cacop_code[33:32], cacop_addr[31:0].
dcache_rdata_bus  out  `EXM_DCACHE_RD (34)  response bus, MSB first: ready[33], rvalid[32], rdata[31:0].

Behaviour:
- Word index is addr[ADDR_WIDTH+1:2]. addr[1:0] and upper address bits are ignored, so addresses alias modulo capacity.
- The block does no byte shifting. rdata is the full word; wdata is already lane-aligned.
- uncached is ignored; it takes the same path as cached accesses.
- Acceptance: a request is accepted at a rising edge when valid=1, ready=1 and reset=1. Requests while ready=0 are ignored, not queued.
- FSM states:
  - IDLE: ready=1.
  - RBUSY: ready=0; latency counter running.
  - RRESP: ready=0, rvalid=1.
  - WBUSY: ready=0; busy counter running.
- IDLE transitions (priority cacop_en > op):
  - cacop_en=1 accept: no memory change. Go to WBUSY with count WR_BUSY, or stay IDLE if WR_BUSY=0.
  - op=1 write accept: at the accept edge, mem[idx] byte lane i takes wdata[8i+7:8i] for each awstrb[i]=1. awstrb=0000 is a legal no-op that still handshakes. Next state is WBUSY with count WR_BUSY, or IDLE if WR_BUSY=0 (back-to-back writes every cycle).
  - op=0 read accept: latch mem[idx] into the read-data register at the accept edge. Go to RRESP if RD_LATENCY=1, else go to RBUSY with count RD_LATENCY-1.
- RBUSY: decrement the counter each cycle; on reaching 1, go to RRESP.
- RRESP: lasts exactly one cycle. rvalid=1, rdata = latched word. Then go to IDLE.
- WBUSY: decrement the counter; go to IDLE when it reaches 1.
- rvalid and ready are never both 1 in the same cycle. rvalid never coincides with the accept cycle of its own read.
- rdata = 0 whenever rvalid=0.
- Timing: a read accepted at edge T has rvalid high in the cycle following edge T+RD_LATENCY-1, i.e. RD_LATENCY cycles after acceptance. ready returns to 1 in the cycle after RRESP.
- Read-after-write: accesses are serialized, so a read accepted after a write always returns the written bytes.
- Reset:
  - FSM goes to IDLE and counters clear.
  - ready=0, rvalid=0, rdata=0 while reset=0; ready=1 from the first cycle after release.
  - An in-flight read is dropped; no rvalid is issued.
  - A write already accepted stays committed.
  - Memory contents are not cleared.
- Out-of-range parameters are a configuration error; an elaboration-time check fails the build.

Test Plan:
- Reset then single write/read: write addr 0x0000_0010, awstrb 1111, wdata 0xDEADBEEF; then read 0x10 -> accepted with ready=1; rvalid exactly 2 cycles after accept, rdata 0xDEADBEEF; ready=0 during RBUSY/RRESP, 1 the cycle after.
- Byte strobes: write 0x11223344 with awstrb 1111 to 0x20, then write 0x0000AA00 with awstrb 0010, read 0x22 -> rdata 0x1122AA44 (addr[1:0] ignored).
- Backpressure: WR_BUSY=3, issue back-to-back writes with valid held -> second accept exactly 4 cycles after the first; no request lost or duplicated.
- Latency sweep: RD_LATENCY=1 and 15 -> rvalid 1 and 15 cycles after accept respectively, one-cycle pulse, never coincident with ready.
- Aliasing/cacop: ADDR_WIDTH=10, write 0xCAFEF00D to 0x0000_1004, read 0x0000_0004 -> 0xCAFEF00D. A cacop_en=1 request with op=1 and awstrb 1111 leaves memory unchanged (re-read returns 0xCAFEF00D).
- Reset mid-read: accept a read with RD_LATENCY=4, drive reset=0 one cycle later for 2 cycles -> no rvalid ever; ready=1 the first cycle after release; a subsequent read returns correct data.
